// File: rtl/dmi_pkg.sv
// Shared definitions for the JTAG debug-bus sequencer.
//   - dmi_op_e     : operation code carried in DR[1:0]
//   - ST_*         : status field values returned at Capture-DR
//   - dmi_state_e  : bus-side FSM states
//   - dr_width()   : DR length for a given address width (data is fixed at 32)
package dmi_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_CLEAR = 2'd3
  } dmi_op_e;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_ERR  = 2'b10;
  localparam logic [1:0] ST_BUSY = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } dmi_state_e;

  function automatic int dr_width(input int addr_w);
    return 2 + addr_w + 32;
  endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Brings raw TAP signals into the system clock domain.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   async_in     : raw TAP signals, bit 0 must be TCK
//   ctrl_sync    : 2-flop synchronized copies of async_in[W-1:1]
//   tck_rise     : one-cycle pulse on a synchronized TCK rising edge
//   tck_fall     : one-cycle pulse on a synchronized TCK falling edge
module jtag_sync_edge #(
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] async_in,
  output logic [W-2:0] ctrl_sync,
  output logic         tck_rise,
  output logic         tck_fall
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic         tck_prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q     <= '0;
      sync_q     <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      meta_q     <= async_in;
      sync_q     <= meta_q;
      tck_prev_q <= sync_q[0];
    end
  end

  // All bits share the same latency, so control levels line up with the TCK edge pulses.
  assign ctrl_sync = sync_q[W-1:1];
  assign tck_rise  = sync_q[0] & ~tck_prev_q;
  assign tck_fall  = ~sync_q[0] & tck_prev_q;

endmodule

// File: rtl/jtag_dmi_sequencer.sv
// Debug-bus access sequencer behind a USER JTAG chain.
// The DR is shifted in the system clock domain; Update-DR launches one bus
// read/write, and its result is returned by the next Capture-DR.
// Ports:
//   clock, reset      : system clock (>= 4x TCK), synchronous active-high reset
//   jtag_*            : raw asynchronous TAP-side signals; jtag_tdo = DR[0] on TCK fall
//   req_valid/ready   : bus request handshake; req_write/addr/wdata held while valid
//   resp_valid/err/rdata : one-cycle response strobe with error flag and read data
//
// state  | meaning
// S_IDLE | no bus access outstanding; updates may launch a request
// S_REQ  | req_valid high, waiting for req_ready
// S_WAIT | request accepted, waiting for resp_valid
module jtag_dmi_sequencer
  import dmi_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32   // only 32 is supported
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              jtag_tck,
  input  logic              jtag_tdi,
  input  logic              jtag_sel,
  input  logic              jtag_capture,
  input  logic              jtag_shift,
  input  logic              jtag_update,
  input  logic              jtag_reset,
  output logic              jtag_tdo,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              resp_valid,
  input  logic              resp_err,
  input  logic [DATA_W-1:0] resp_rdata
);

  localparam int DR_W = dr_width(ADDR_W);

  logic [5:0] ctrl_s;
  logic       tck_rise, tck_fall;
  logic       tdi_s, sel_s, capture_s, shift_s, update_s, jreset_s;

  jtag_sync_edge #(.W(7)) u_sync (
    .clock     (clock),
    .reset     (reset),
    .async_in  ({jtag_reset, jtag_update, jtag_shift, jtag_capture,
                 jtag_sel, jtag_tdi, jtag_tck}),
    .ctrl_sync (ctrl_s),
    .tck_rise  (tck_rise),
    .tck_fall  (tck_fall)
  );

  assign {jreset_s, update_s, shift_s, capture_s, sel_s, tdi_s} = ctrl_s;

  dmi_state_e        state_q, state_d;
  logic [DR_W-1:0]   dr_q, dr_d;
  logic              tdo_q, tdo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        status_q, status_d;
  logic              write_q, write_d;
  logic              req_valid_q, req_valid_d;

  logic    update_stb, resp_take;
  dmi_op_e op;

  assign op         = dmi_op_e'(dr_q[1:0]);
  assign update_stb = sel_s & update_s & tck_rise;
  // A response is only meaningful once the request has been (or is being) accepted.
  assign resp_take  = resp_valid & ((state_q == S_WAIT) ||
                                    (state_q == S_REQ && req_ready));

  always_comb begin
    state_d     = state_q;
    dr_d        = dr_q;
    tdo_d       = tdo_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    write_d     = write_q;
    req_valid_d = req_valid_q;

    if (sel_s && tck_rise) begin
      if (capture_s)
        dr_d = {rdata_q, addr_q, (state_q == S_IDLE) ? status_q : ST_BUSY};
      else if (shift_s)
        dr_d = {tdi_s, dr_q[DR_W-1:1]};
    end
    if (sel_s && tck_fall)
      tdo_d = dr_q[0];

    case (state_q)
      S_REQ: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          state_d     = resp_valid ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp_valid) state_d = S_IDLE;
      end
      default: ;
    endcase

    if (resp_take) begin
      if (!write_q) rdata_d = resp_rdata;
      if (resp_err) status_d = ST_ERR;
    end

    // Overrun marking follows response handling so it wins if both land together.
    if (update_stb) begin
      case (op)
        OP_CLEAR: status_d = ST_OK;
        OP_READ, OP_WRITE: begin
          if (state_q == S_IDLE) begin
            addr_d      = dr_q[ADDR_W+1:2];
            wdata_d     = dr_q[DR_W-1:ADDR_W+2];
            write_d     = (op == OP_WRITE);
            req_valid_d = 1'b1;
            state_d     = S_REQ;
          end else begin
            status_d = ST_BUSY;
          end
        end
        default: ;
      endcase
    end
  end

  // TAP reset abandons any pending request without waiting for req_ready.
  always_ff @(posedge clock) begin
    if (reset || jreset_s) begin
      state_q     <= S_IDLE;
      dr_q        <= '0;
      tdo_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      status_q    <= ST_OK;
      write_q     <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dr_q        <= dr_d;
      tdo_q       <= tdo_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
      write_q     <= write_d;
      req_valid_q <= req_valid_d;
    end
  end

  assign jtag_tdo  = tdo_q;
  assign req_valid = req_valid_q;
  assign req_write = write_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;

endmodule

// File: tb/tb_jtag_dmi_sequencer.sv
`timescale 1ns/1ps
module tb_jtag_dmi_sequencer;

  localparam int ADDR_W = 7;
  localparam int DR_W   = 41;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic jtag_tck = 0, jtag_tdi = 0, jtag_sel = 0, jtag_capture = 0;
  logic jtag_shift = 0, jtag_update = 0, jtag_reset = 0;
  logic jtag_tdo;
  logic req_valid, req_write;
  logic req_ready = 0;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic resp_valid = 0, resp_err = 0;
  logic [31:0] resp_rdata = '0;

  jtag_dmi_sequencer #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .jtag_tck(jtag_tck), .jtag_tdi(jtag_tdi), .jtag_sel(jtag_sel),
    .jtag_capture(jtag_capture), .jtag_shift(jtag_shift),
    .jtag_update(jtag_update), .jtag_reset(jtag_reset), .jtag_tdo(jtag_tdo),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level reference state
  logic [1:0]        m_status = 0;
  logic [ADDR_W-1:0] m_addr = 0;
  logic [31:0]       m_rdata = 0, m_wdata = 0;
  logic              m_write = 0, m_busy = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [DR_W-1:0] exp_cap();
    return {m_rdata, m_addr, m_busy ? 2'b11 : m_status};
  endfunction

  function automatic void model_update(input logic [DR_W-1:0] din);
    case (din[1:0])
      2'd3: m_status = 2'b00;
      2'd1, 2'd2: begin
        if (!m_busy) begin
          m_busy = 1; m_write = (din[1:0] == 2'd2);
          m_addr = din[8:2]; m_wdata = din[40:9];
        end else m_status = 2'b11;
      end
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    m_status = 0; m_addr = 0; m_rdata = 0; m_wdata = 0; m_write = 0; m_busy = 0;
  endfunction

  // One TCK period; TDO is sampled just before the rising edge.
  task automatic tck_pulse(output logic tdo_s);
    cyc(2);
    tdo_s = jtag_tdo;
    jtag_tck = 1; cyc(5);
    jtag_tck = 0; cyc(5);
  endtask

  task automatic scan(input bit do_cap, input bit do_upd, input logic [DR_W-1:0] din,
                      output logic [DR_W-1:0] dout);
    logic t;
    jtag_sel = 1;
    if (do_cap) begin jtag_capture = 1; tck_pulse(t); jtag_capture = 0; end
    jtag_shift = 1;
    for (int i = 0; i < DR_W; i++) begin
      jtag_tdi = din[i];
      tck_pulse(t);
      dout[i] = t;
    end
    jtag_shift = 0;
    if (do_upd) begin
      jtag_update = 1; tck_pulse(t); jtag_update = 0;
      model_update(din);
    end
  endtask

  task automatic do_xact(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         output logic [DR_W-1:0] cap);
    logic [DR_W-1:0] e;
    e = exp_cap();
    scan(1, 1, {d, a, op}, cap);
    chk("capture", cap, e);
  endtask

  task automatic serve(input int rdly, input int pdly, input bit err, input logic [31:0] rd);
    int n = 0;
    while (req_valid !== 1'b1 && n < 40) begin cyc(1); n++; end
    chk("req_seen", req_valid, 1);
    if (req_valid !== 1'b1) return;
    chk("req_write", req_write, m_write);
    chk("req_addr", req_addr, m_addr);
    chk("req_wdata", req_wdata, m_wdata);
    for (int i = 0; i < rdly; i++) begin
      // A stray response before acceptance must be ignored.
      resp_valid = (i == 0); resp_err = 1; resp_rdata = $urandom;
      cyc(1);
      resp_valid = 0; resp_err = 0;
      chk("req_hold", {req_valid, req_write, req_addr, req_wdata}, {1'b1, m_write, m_addr, m_wdata});
    end
    req_ready = 1;
    if (pdly == 0) begin resp_valid = 1; resp_err = err; resp_rdata = rd; end
    cyc(1);
    req_ready = 0; resp_valid = 0; resp_err = 0;
    for (int i = 1; i < pdly; i++) cyc(1);
    if (pdly > 0) begin
      chk("req_drop", req_valid, 0);
      resp_valid = 1; resp_err = err; resp_rdata = rd;
      cyc(1);
      resp_valid = 0; resp_err = 0;
    end
    if (!m_write) m_rdata = rd;
    if (err) m_status = 2'b10;
    m_busy = 0;
    cyc(1);
    chk("req_done", req_valid, 0);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DR_W-1:0] cap, pat, back;
    int n;
    bit bad;

    cyc(4);
    reset = 0;
    cyc(2);
    chk("rst_outputs", {req_valid, req_write, req_addr, req_wdata, jtag_tdo}, 0);

    // Write with three cycles of back-pressure
    do_xact(2'd2, 7'h10, 32'hDEADBEEF, cap);
    chk("wr_fields", {req_valid, req_write, req_addr, req_wdata}, {1'b1, 1'b1, 7'h10, 32'hDEADBEEF});
    serve(3, 2, 0, 32'h0);

    // Read, then capture returns its data
    do_xact(2'd1, 7'h11, 32'h0, cap);
    serve(1, 1, 0, 32'h12345678);
    do_xact(2'd0, 7'h0, 32'h0, cap);
    chk("read_cap", cap, {32'h12345678, 7'h11, 2'b00});

    // Overrun: second update while the first is still unaccepted
    do_xact(2'd2, 7'h20, 32'hA5A5_0001, cap);
    cyc(5);
    do_xact(2'd1, 7'h21, 32'h0, cap);
    chk("ovr_busy", cap[1:0], 2'b11);
    chk("ovr_hold", {req_write, req_addr}, {1'b1, 7'h20});
    serve(0, 1, 0, 32'h0);
    do_xact(2'd3, 7'h0, 32'h0, cap);
    chk("ovr_sticky", cap[1:0], 2'b11);
    do_xact(2'd0, 7'h0, 32'h0, cap);
    chk("ovr_clear", cap[1:0], 2'b00);

    // Error is sticky across a good read
    do_xact(2'd1, 7'h30, 32'h0, cap);
    serve(0, 2, 1, 32'h0BAD_0BAD);
    do_xact(2'd1, 7'h31, 32'h0, cap);
    chk("err_status", cap[1:0], 2'b10);
    serve(1, 1, 0, 32'hCAFE_F00D);
    do_xact(2'd3, 7'h0, 32'h0, cap);
    chk("err_persist", cap, {32'hCAFE_F00D, 7'h31, 2'b10});
    do_xact(2'd0, 7'h0, 32'h0, cap);
    chk("err_clear", cap[1:0], 2'b00);

    // TAP reset in the middle of a request
    do_xact(2'd2, 7'h55, 32'h1234_ABCD, cap);
    chk("rst_pre_valid", req_valid, 1);
    jtag_reset = 1;
    n = 0;
    while (req_valid !== 1'b0 && n < 10) begin cyc(1); n++; end
    chk("rst_drop_lat", n, 3);
    jtag_reset = 0;
    cyc(5);
    model_reset();
    chk("rst_tdo", jtag_tdo, 0);
    do_xact(2'd0, 7'h0, 32'h0, cap);
    chk("rst_cap", cap, 0);

    // Edges with sel low must not disturb the DR or launch a request
    pat = {$urandom, $urandom};
    scan(0, 0, pat, back);
    jtag_sel = 0; jtag_shift = 1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      logic t;
      jtag_tdi = $urandom_range(0, 1);
      jtag_update = (i % 7 == 3);
      tck_pulse(t);
      if (req_valid !== 1'b0) bad = 1;
    end
    jtag_update = 0; jtag_shift = 0;
    chk("sel0_noreq", bad, 0);
    scan(0, 0, '0, back);
    chk("sel0_dr", back, pat);

    // Ready and response in the same cycle
    do_xact(2'd1, 7'h42, 32'h0, cap);
    serve(0, 0, 0, 32'h7777_1111);
    do_xact(2'd0, 7'h0, 32'h0, cap);
    chk("same_cyc", cap, {32'h7777_1111, 7'h42, 2'b00});

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      do_xact(op, 7'($urandom), $urandom, cap);
      if (m_busy) begin
        serve($urandom_range(0, 4), $urandom_range(0, 3),
              ($urandom_range(0, 4) == 0), $urandom);
      end else if ($urandom_range(0, 1) == 1) begin
        resp_valid = 1; resp_err = 1; resp_rdata = $urandom;
        cyc(1);
        resp_valid = 0; resp_err = 0;
      end
    end
    do_xact(2'd0, 7'h0, 32'h0, cap);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
